cdl_rdback: RTL



---
 rtl/cdl_rdback.sv | 133 +++++++++++++
 1 files changed

// File: rtl/cdl_rdback.sv
// cdl_rdback: read-back responder for a small CDL register bank.
//
// The hardware side updates registers through a simple write port. A host
// reads them back over a request/valid/ready handshake. Each read goes
// IDLE -> FETCH -> RESP. The response is a snapshot that is held until the
// host accepts it.
//
// Ports:
//   clk       clock, all logic on posedge
//   reset     asynchronous, active-high reset
//   hw_we     hardware write enable
//   hw_addr   hardware write address (writes with hw_addr >= NREG are dropped)
//   hw_wdata  hardware write data
//   rd_req    read request, sampled only while idle
//   rd_addr   read address, sampled with rd_req
//   rd_busy   responder is not idle
//   rd_vld    response valid
//   rd_data   read data, held while rd_vld=1 and after the handshake
//   rd_err    read address was out of range
//   rd_rdy    host accepts the response
//   rd_cnt    saturating count of completed reads (error reads included)
module cdl_rdback #(
    parameter int              NREG      = 8,
    parameter int              AW        = 3,
    parameter int              DW        = 8,
    parameter logic [DW-1:0]   RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hw_we,
    input  logic [AW-1:0] hw_addr,
    input  logic [DW-1:0] hw_wdata,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_busy,
    output logic          rd_vld,
    output logic [DW-1:0] rd_data,
    output logic          rd_err,
    input  logic          rd_rdy,
    output logic [7:0]    rd_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] data_reg;
    logic          err_reg;
    logic [7:0]    cnt_reg;
    logic [DW-1:0] regs [NREG];

    logic          fetch_in_range;
    logic [DW-1:0] reg_rd;
    logic [DW-1:0] fetch_data;

    // Register bank. Only addresses that match an existing register are
    // written, so out-of-range writes fall through silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (hw_we && (hw_addr == AW'(i))) begin
                    regs[i] <= hw_wdata;
                end
            end
        end
    end

    // The extra bit avoids a wrap when NREG == 2**AW.
    assign fetch_in_range = ({1'b0, addr_reg} < (AW+1)'(NREG));

    always_comb begin
        reg_rd = '0;
        for (int i = 0; i < NREG; i++) begin
            if (addr_reg == AW'(i)) begin
                reg_rd = regs[i];
            end
        end
    end

    // A write landing on the captured address in the FETCH cycle would only
    // reach the bank on the same edge as the capture. Forward it so the read
    // returns the newest value.
    assign fetch_data = (hw_we && (hw_addr == addr_reg)) ? hw_wdata : reg_rd;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (rd_req) state_next = FETCH;
            FETCH:   state_next = RESP;
            RESP:    if (rd_rdy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && rd_req) begin
                addr_reg <= rd_addr;
            end
            if (state_reg == FETCH) begin
                data_reg <= fetch_in_range ? fetch_data : '0;
                err_reg  <= !fetch_in_range;
            end
            if ((state_reg == RESP) && rd_rdy && (cnt_reg != 8'hFF)) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    // These are decoded straight from the state register, so an asynchronous
    // reset drops them at once, without waiting for a clock edge.
    assign rd_busy = (state_reg != IDLE);
    assign rd_vld  = (state_reg == RESP);
    assign rd_data = data_reg;
    assign rd_err  = err_reg;
    assign rd_cnt  = cnt_reg;

endmodule
